// File: rtl/bram_port_initiator.sv
// Command-driven initiator for a 32-bit BRAM_CTRL-style register port.
// Turns READ / WRITE / POLL commands into single port accesses and returns one response each.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | one-cycle port access (en high)
// WAIT  | RD_LATENCY cycles until dout is valid
// GAP   | idle spacing between poll attempts
// RESP  | response held until accepted
module bram_port_initiator #(
  parameter int RD_LATENCY = 1,
  parameter int POLL_MAX   = 1024,
  parameter int POLL_GAP   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] bram_addr_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_din_o,
  input  logic [31:0] bram_dout_i,
  output logic        bram_rst_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_RESP} state_t;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_POLL    = 2'b10;
  localparam logic [1:0] OP_BAD     = 2'b11;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADOP   = 2'b10;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_addr, r_din, r_cmp, r_mask;
  logic [3:0]  r_be;
  logic [15:0] r_attempts;
  logic [2:0]  r_wait;
  logic [7:0]  r_gap;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_status;
  logic        r_bram_rst;

  logic w_accept, w_match, w_wait_done, w_poll_last;

  assign cmd_ready_o = (r_state == S_IDLE) & ~r_bram_rst;
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_match     = ((bram_dout_i ^ r_cmp) & r_mask) == 32'h0;
  assign w_wait_done = (r_wait == 3'd0);
  assign w_poll_last = (r_attempts == 16'(POLL_MAX));

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (cmd_op_i == OP_BAD) ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_wait_done) begin
          if (r_op != OP_POLL || w_match || w_poll_last) w_state_nxt = S_RESP;
          else if (POLL_GAP == 0)                        w_state_nxt = S_ISSUE;
          else                                           w_state_nxt = S_GAP;
        end
      end
      S_GAP:   if (r_gap == 8'd0) w_state_nxt = S_ISSUE;
      S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      r_op         <= 2'b00;
      r_addr       <= 32'h0;
      r_din        <= 32'h0;
      r_cmp        <= 32'h0;
      r_mask       <= 32'h0;
      r_be         <= 4'h0;
      r_attempts   <= 16'h0;
      r_wait       <= 3'h0;
      r_gap        <= 8'h0;
      r_rsp_data   <= 32'h0;
      r_rsp_status <= ST_OK;
      r_bram_rst   <= 1'b1;
    end else begin
      r_bram_rst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= cmd_op_i;
            r_cmp      <= cmd_data_i;
            r_mask     <= cmd_mask_i;
            r_be       <= cmd_be_i;
            r_attempts <= 16'h0;
            // addr/din only move when a real access follows, so they hold otherwise
            if (cmd_op_i != OP_BAD) r_addr <= cmd_addr_i & 32'hFFFF_FFFC;
            if (cmd_op_i == OP_WRITE) r_din <= cmd_data_i;
            if (cmd_op_i == OP_BAD) begin
              r_rsp_data   <= 32'h0;
              r_rsp_status <= ST_BADOP;
            end
          end
        end
        S_ISSUE: begin
          r_attempts <= r_attempts + 16'd1;
          r_wait     <= 3'(RD_LATENCY - 1);
        end
        S_WAIT: begin
          if (!w_wait_done) begin
            r_wait <= r_wait - 3'd1;
          end else begin
            r_rsp_data   <= bram_dout_i;
            r_rsp_status <= (r_op == OP_POLL && !w_match) ? ST_TIMEOUT : ST_OK;
            r_gap        <= 8'(POLL_GAP - 1);
          end
        end
        S_GAP:   r_gap <= r_gap - 8'd1;
        default: ;
      endcase
    end
  end

  assign bram_en_o    = (r_state == S_ISSUE);
  assign bram_we_o    = (r_state == S_ISSUE && r_op == OP_WRITE) ? r_be : 4'h0;
  assign bram_addr_o  = r_addr;
  assign bram_din_o   = r_din;
  assign bram_rst_o   = r_bram_rst;
  assign rsp_valid_o  = (r_state == S_RESP);
  assign rsp_data_o   = r_rsp_data;
  assign rsp_status_o = r_rsp_status;

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator with a 4-register responder model
// (RD_LATENCY=1, writes echoed on dout, reg0[0] self-clears one cycle after being set).
module tb_bram_port_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = 32'h0, cmd_data = 32'h0, cmd_mask = 32'h0;
  logic [3:0]  cmd_be = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [31:0] bram_addr, bram_din, bram_dout;
  logic        bram_en, bram_rst;
  logic [3:0]  bram_we;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_port_initiator #(.RD_LATENCY(1), .POLL_MAX(3), .POLL_GAP(2)) dut (
    .clk_i(clk), .rst_i_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_be_i(cmd_be), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
    .bram_addr_o(bram_addr), .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_din_o(bram_din),
    .bram_dout_i(bram_dout), .bram_rst_o(bram_rst)
  );

  // responder model
  logic [31:0] mem [4];
  logic        clr0 = 1'b0;
  logic [1:0]  w_idx;
  logic [31:0] w_merged;
  assign w_idx    = bram_addr[3:2];
  assign w_merged = {bram_we[3] ? bram_din[31:24] : mem[w_idx][31:24],
                     bram_we[2] ? bram_din[23:16] : mem[w_idx][23:16],
                     bram_we[1] ? bram_din[15:8]  : mem[w_idx][15:8],
                     bram_we[0] ? bram_din[7:0]   : mem[w_idx][7:0]};

  always @(posedge clk) begin
    if (bram_rst) begin
      bram_dout <= 32'h0;
      clr0      <= 1'b0;
    end else begin
      clr0 <= 1'b0;
      if (clr0) mem[0][0] <= 1'b0;
      if (bram_en) begin
        if (|bram_we) begin
          mem[w_idx] <= w_merged;
          bram_dout  <= w_merged;
          if (w_idx == 2'd0 && w_merged[0]) clr0 <= 1'b1;
        end else begin
          bram_dout <= mem[w_idx];
        end
      end
    end
  end

  // results of the last run_cmd
  int          rsp_k;
  int          en_n;
  int          en_k [8];
  logic [3:0]  en_we [8];
  logic [31:0] en_addr [8];
  logic [31:0] en_din [8];
  logic [31:0] got_data;
  logic [1:0]  got_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // k counts negedges after the accept edge, so k == n means cycle T+n
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [31:0] mask, input int hold);
    int n;
    int k;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_be = be; cmd_mask = mask;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("cmd_ready_timeout", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    en_n = 0;
    while (k < 200) begin
      if (bram_en) begin
        if (en_n < 8) begin
          en_k[en_n] = k; en_we[en_n] = bram_we; en_addr[en_n] = bram_addr; en_din[en_n] = bram_din;
        end
        en_n++;
      end
      if (cmd_ready) check("ready_low_busy", 32'(cmd_ready), 32'h0);
      if (rsp_valid) break;
      @(negedge clk);
      k++;
    end
    rsp_k = k;
    if (k >= 200) check("rsp_valid_timeout", 32'(rsp_valid), 32'h1);
    got_data   = rsp_data;
    got_status = rsp_status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_data", rsp_data, got_data);
      check("hold_status", 32'(rsp_status), 32'(got_status));
      check("hold_ready", 32'(cmd_ready), 32'h0);
      check("hold_no_en", 32'(bram_en), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #23;
    check("rst_ready", 32'(cmd_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_en", 32'(bram_en), 32'h0);
    check("rst_we", 32'(bram_we), 32'h0);
    check("rst_addr", bram_addr, 32'h0);
    check("rst_bram_rst", 32'(bram_rst), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rel_bram_rst", 32'(bram_rst), 32'h0);
    check("rel_ready", 32'(cmd_ready), 32'h1);

    // preload reg1
    run_cmd(2'b01, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    check("wr1_status", 32'(got_status), 32'h0);

    // READ 0x4
    run_cmd(2'b00, 32'h4, 32'h0, 4'h0, 32'h0, 0);
    check("rd_en_count", en_n, 1);
    check("rd_en_cycle", en_k[0], 1);
    check("rd_we", 32'(en_we[0]), 32'h0);
    check("rd_addr", en_addr[0], 32'h4);
    check("rd_rsp_cycle", rsp_k, 3);
    check("rd_data", got_data, 32'hDEADBEEF);
    check("rd_status", 32'(got_status), 32'h0);

    // WRITE 0x8 partial bytes over all-ones
    run_cmd(2'b01, 32'h8, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
    run_cmd(2'b01, 32'h8, 32'h12345678, 4'b0101, 32'h0, 0);
    check("wr_en_count", en_n, 1);
    check("wr_we", 32'(en_we[0]), 32'h5);
    check("wr_din", en_din[0], 32'h12345678);
    check("wr_rsp_cycle", rsp_k, 3);
    check("wr_echo", got_data, 32'hFF34FF78);
    check("wr_status", 32'(got_status), 32'h0);

    // READ back with response back-pressure, low address bits ignored
    run_cmd(2'b00, 32'hB, 32'h0, 4'h0, 32'h0, 5);
    check("bp_addr", en_addr[0], 32'h8);
    check("bp_data", got_data, 32'hFF34FF78);
    check("bp_status", 32'(got_status), 32'h0);

    // POLL for self-clearing bit
    run_cmd(2'b01, 32'h0, 32'h1, 4'hF, 32'h0, 0);
    run_cmd(2'b10, 32'h0, 32'h0, 4'h0, 32'h1, 0);
    check("poll_attempts_le2", 32'(en_n <= 2), 32'h1);
    check("poll_we", 32'(en_we[0]), 32'h0);
    check("poll_status", 32'(got_status), 32'h0);
    check("poll_bit0", 32'(got_data[0]), 32'h0);

    // POLL timeout: 3 attempts, each ISSUE + WAIT + 2 GAP cycles apart
    run_cmd(2'b10, 32'h4, 32'h0, 4'h0, 32'hFFFFFFFF, 0);
    check("to_en_count", en_n, 3);
    check("to_en0", en_k[0], 1);
    check("to_en1", en_k[1], 5);
    check("to_en2", en_k[2], 9);
    check("to_rsp_cycle", rsp_k, 11);
    check("to_status", 32'(got_status), 32'h1);
    check("to_data", got_data, 32'hDEADBEEF);

    // reserved op
    run_cmd(2'b11, 32'hC, 32'h55, 4'hF, 32'h0, 0);
    check("bad_en_count", en_n, 0);
    check("bad_rsp_cycle", rsp_k, 1);
    check("bad_status", 32'(got_status), 32'h2);
    check("bad_data", got_data, 32'h0);
    check("bad_addr_hold", bram_addr, 32'h4);

    // reset during the WAIT of a POLL
    @(negedge clk);
    cmd_op = 2'b10; cmd_addr = 32'h4; cmd_data = 32'h0; cmd_mask = 32'hFFFFFFFF; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_issue_en", 32'(bram_en), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(bram_en), 32'h0);
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_bram_rst", 32'(bram_rst), 32'h1);
    check("mid_rst_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    run_cmd(2'b00, 32'h6, 32'h0, 4'h0, 32'h0, 0);
    check("post_rst_en_count", en_n, 1);
    check("post_rst_rsp_cycle", rsp_k, 3);
    check("post_rst_data", got_data, 32'hDEADBEEF);
    check("post_rst_status", 32'(got_status), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
